and2_share_arbiter: RTL and testbench
=====================================

Name: and2_share_arbiter

Overview:
Shares one WIDTH-bit bitwise-AND datapath between NREQ requesters. Each requester presents an operand pair (I0, I1) with a valid/ready handshake. A round-robin arbiter grants one requester per accept slot and drives the shared AND unit. The result is registered and returned with the requester's id through a single response channel with its own valid/ready handshake. The block sits between multiple generated client circuits and the single And2-based logic resource.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 8, operand/result width in bits
IDW, 2, width of resp_id; equals clog2(NREQ)

Ports:
CLK  input  1  clock, rising edge
ASYNCRESETN  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept; one-hot or zero
req_I0  input  NREQ*WIDTH  operand 0; requester i in bits [i*WIDTH +: WIDTH]
req_I1  input  NREQ*WIDTH  operand 1; same packing as req_I0
resp_valid  output  1  response holds a result
resp_id  output  IDW  index of the requester that owns the result
resp_O  output  WIDTH  registered I0 & I1
resp_ready  input  1  consumer accepts the response

Behaviour:
- Reset (ASYNCRESETN=0, asynchronous assert, synchronous release): state IDLE; resp_valid=0; resp_id=0; resp_O=0; priority pointer ptr=0. req_ready is 0 while reset is held. Any held result is discarded.
- States: IDLE (no result held) and HOLD (result held, resp_valid=1).
- can_accept = (state==IDLE) | (state==HOLD & resp_ready).
- Grant: g is the first i with req_valid[i]=1, scanning from ptr upward modulo NREQ. It is combinational from req_valid and ptr.
- req_ready[g] = can_accept & |req_valid. All other req_ready bits are 0. req_ready never depends on req_I0 or req_I1.
- Accept on edge when req_valid[g] & req_ready[g]:
  - resp_O <= req_I0[g] & req_I1[g], through the shared AND unit.
  - resp_id <= g.
  - ptr <= (g+1) mod NREQ.
  - state <= HOLD.
- Latency: resp_valid rises on the cycle after acceptance (1 cycle).
- HOLD with resp_ready=1 and no request pending: state <= IDLE and resp_valid drops next cycle. resp_O and resp_id keep their last values.
- HOLD with resp_ready=1 and a request pending: pop and accept happen in the same cycle. resp_valid stays 1 and the new result appears next cycle. This gives full throughput of one op per cycle.
- HOLD with resp_ready=0: resp_valid, resp_id and resp_O stay stable. All req_ready bits are 0.
- ptr changes only on accept. Requesters not granted keep their position, which guarantees starvation-freedom. No requester waits more than NREQ accepts.
- Deasserting req_valid before it is accepted is permitted. The grant re-evaluates every cycle.
- Reset asserted mid-HOLD: response is lost, resp_valid goes to 0 immediately, ptr=0.

Decomposition:
- Shared package (and2_share_pkg):
  - state encoding constants ST_IDLE=0 and ST_HOLD=1.
  - default NREQ and WIDTH.
  - the function computing IDW from NREQ.
- Sub-module and2_vec:
  - WIDTH instances of the existing And2 primitive, one per bit (I0, I1 -> O).
  - It is the only shared datapath. The arbiter muxes the granted operands into it.
- The round-robin pick stays inline.

Test Plan:
- Single request: after reset, req_valid=0001, I0[0]=0xF0, I1[0]=0x3C, resp_ready=1.
  - Expect req_ready=0001 in that cycle.
  - Next cycle: resp_valid=1, resp_id=0, resp_O=0x30.
  - The cycle after: resp_valid=0.
- Round robin: req_valid=1111 held, resp_ready=1, distinct operands.
  - Grants occur in order 0,1,2,3,0 on consecutive cycles.
  - resp_valid stays continuously 1 from the second cycle; each resp_O matches its operand pair.
- Backpressure: one result held, resp_ready=0 for 5 cycles, req_valid=0110.
  - req_ready=0000 and resp_* stable for all 5 cycles.
  - Raise resp_ready: requester 1 is granted in that same cycle, then requester 2 on the next accept.
- Pointer fairness: ptr=2 after granting 1, req_valid=1011 -> grant 3 first, then 0, then 1.
- Reset mid-operation: in HOLD with resp_id=2, assert ASYNCRESETN=0 between clock edges.
  - resp_valid=0 with no clock edge needed.
  - After release, with req_valid=1111, the first grant is 0.
- Width boundary: WIDTH=8, I0=0xFF, I1=0xFF gives 0xFF; I0=0xAA, I1=0x55 gives 0x00.

Source files
------------

// File: rtl/and2_share_pkg.sv
// Shared definitions for the AND-sharing arbiter: state encoding, default sizes
// and the id-width helper.
package and2_share_pkg;

  localparam int unsigned DefNreq  = 4;
  localparam int unsigned DefWidth = 8;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  // At least one id bit so a two-requester build still has a usable id port.
  function automatic int unsigned idw_calc(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/And2.sv
// Single-bit two-input AND primitive used as the shared logic resource.
module And2 (
  input  logic I0,
  input  logic I1,
  output logic O
);

  assign O = I0 & I1;

endmodule

// File: rtl/and2_vec.sv
// WIDTH-bit AND built from one And2 primitive per bit; the only datapath shared
// by all requesters.
module and2_vec #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  output logic [WIDTH-1:0] O
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    And2 u_and2 (
      .I0 (I0[b]),
      .I1 (I1[b]),
      .O  (O[b])
    );
  end

endmodule

// File: rtl/and2_share_arbiter.sv
// Round-robin arbiter sharing one AND datapath between NREQ requesters, with a
// registered single-entry response channel that sustains one op per cycle.
module and2_share_arbiter
  import and2_share_pkg::*;
#(
  parameter int unsigned NREQ  = DefNreq,
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned IDW   = idw_calc(NREQ)
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESETN,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_I0,
  input  logic [NREQ*WIDTH-1:0] req_I1,
  output logic                  resp_valid,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_O,
  input  logic                  resp_ready
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] o_q, o_d;

  logic [IDW-1:0]   grant;
  logic             any_valid;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] op0, op1, and_out;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    grant     = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        grant     = IDW'(idx);
      end
    end
  end

  assign can_accept = (state_q == StIdle) || resp_ready;

  always_comb begin
    req_ready = '0;
    if (ASYNCRESETN && can_accept && any_valid) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign accept = |req_ready;

  assign op0 = req_I0[grant*WIDTH +: WIDTH];
  assign op1 = req_I1[grant*WIDTH +: WIDTH];

  and2_vec #(
    .WIDTH (WIDTH)
  ) u_and2_vec (
    .I0 (op0),
    .I1 (op1),
    .O  (and_out)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    o_d     = o_q;
    if (accept) begin
      state_d = StHold;
      ptr_d   = IDW'((int'(grant) + 1) % NREQ);
      id_d    = grant;
      o_d     = and_out;
    end else if (state_q == StHold && resp_ready) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      o_q     <= o_d;
    end
  end

  assign resp_valid = (state_q == StHold);
  assign resp_id    = id_q;
  assign resp_O     = o_q;

endmodule

// File: tb/tb_and2_share_arbiter.sv
// Directed bench for and2_share_arbiter with hand-computed expected values.
module tb_and2_share_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_i0;
  logic [NREQ*WIDTH-1:0] req_i1;
  logic                  resp_valid;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_o;
  logic                  resp_ready;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  and2_share_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) dut (
    .CLK         (clk),
    .ASYNCRESETN (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_I0      (req_i0),
    .req_I1      (req_i1),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_O      (resp_o),
    .resp_ready  (resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    req_i0[i*WIDTH +: WIDTH] = a;
    req_i1[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic check_resp(input string tag, input logic v, input logic [1:0] id,
                            input logic [7:0] o);
    check({tag, "_valid"}, 32'(resp_valid), 32'(v));
    check({tag, "_id"}, 32'(resp_id), 32'(id));
    check({tag, "_O"}, 32'(resp_o), 32'(o));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check_resp("rst", 1'b0, 2'd0, 8'h00);
    repeat (2) @(posedge clk);
    #3;
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    #1;
  endtask

  // Round-robin operands and their AND results.
  logic [7:0] rr_a [4] = '{8'h0F, 8'hAA, 8'hCC, 8'hF0};
  logic [7:0] rr_b [4] = '{8'h3C, 8'h0F, 8'h66, 8'hFF};
  logic [7:0] rr_r [4] = '{8'h0C, 8'h0A, 8'h44, 8'hF0};

  initial begin
    req_valid  = '0;
    req_i0     = '0;
    req_i1     = '0;
    resp_ready = 1'b0;
    rst_n      = 1'b0;

    do_reset();

    // Single request.
    set_ops(0, 8'hF0, 8'h3C);
    req_valid  = 4'b0001;
    resp_ready = 1'b1;
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0000;
    check_resp("single", 1'b1, 2'd0, 8'h30);
    step();
    check("single_drop", 32'(resp_valid), 32'h0);

    // Round robin from a fresh pointer.
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, rr_a[i], rr_b[i]);
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      step();
      check_resp($sformatf("rr%0d", k), 1'b1, 2'(k % 4), rr_r[k % 4]);
    end
    req_valid = 4'b0000;
    step();
    check("rr_drop", 32'(resp_valid), 32'h0);

    // Backpressure: hold requester 0's result (ptr becomes 1).
    set_ops(0, 8'hF0, 8'h3C);
    req_valid  = 4'b0001;
    resp_ready = 1'b0;
    step();
    set_ops(0, rr_a[0], rr_b[0]);
    req_valid = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_ready%0d", k), 32'(req_ready), 32'h0);
      check_resp($sformatf("bp%0d", k), 1'b1, 2'd0, 8'h30);
      step();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_grant1", 32'(req_ready), 32'h2);
    step();
    check_resp("bp_r1", 1'b1, 2'd1, 8'h0A);
    check("bp_grant2", 32'(req_ready), 32'h4);
    step();
    check_resp("bp_r2", 1'b1, 2'd2, 8'h44);

    // Pointer fairness: grant 1 (ptr -> 2), then 1011 yields 3, 0, 1.
    req_valid = 4'b0010;
    #1;
    check("pf_g1", 32'(req_ready), 32'h2);
    step();
    check_resp("pf_r1", 1'b1, 2'd1, 8'h0A);
    req_valid = 4'b1011;
    #1;
    check("pf_g3", 32'(req_ready), 32'h8);
    step();
    check_resp("pf_r3", 1'b1, 2'd3, 8'hF0);
    check("pf_g0", 32'(req_ready), 32'h1);
    step();
    check_resp("pf_r0", 1'b1, 2'd0, 8'h0C);
    check("pf_g1b", 32'(req_ready), 32'h2);
    step();
    check_resp("pf_r1b", 1'b1, 2'd1, 8'h0A);

    // Reset in the middle of HOLD with resp_id=2.
    req_valid = 4'b0100;
    step();
    req_valid  = 4'b0000;
    resp_ready = 1'b0;
    step();
    check_resp("mr_hold", 1'b1, 2'd2, 8'h44);
    #2;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    check_resp("mr_rst", 1'b0, 2'd0, 8'h00);
    check("mr_ready", 32'(req_ready), 32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    check("mr_first", 32'(req_ready), 32'h1);
    resp_ready = 1'b1;
    step();
    check_resp("mr_r0", 1'b1, 2'd0, 8'h0C);

    // Width boundaries (ptr=1, only requester 0 asking).
    req_valid = 4'b0001;
    set_ops(0, 8'hFF, 8'hFF);
    #1;
    check("wb_ready", 32'(req_ready), 32'h1);
    step();
    check_resp("wb_ff", 1'b1, 2'd0, 8'hFF);
    set_ops(0, 8'hAA, 8'h55);
    step();
    check_resp("wb_00", 1'b1, 2'd0, 8'h00);
    req_valid = 4'b0000;
    step();
    check("wb_drop", 32'(resp_valid), 32'h0);
    check("wb_keep_O", 32'(resp_o), 32'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
